sifive_scope_tl_d_capture: RTL and testbench

//  Parametrised capture engine for a TileLink D channel in the scope subsystem.

---
 rtl/sifive_scope_tl_d_capture.sv | 128 ++++++++++++
 tb/tb_sifive_scope_tl_d_capture.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sifive_scope_tl_d_capture.sv
// TileLink D-channel capture engine: snoops handshaken beats, filters by opcode,
// timestamps them and buffers packed records in a FIFO drained over valid/ready.
module sifive_scope_tl_d_capture #(
   parameter int DATA_W   = 32,
   parameter int SOURCE_W = 3,
   parameter int SINK_W   = 1,
   parameter int SIZE_W   = 4,
   parameter int TS_W     = 16,
   parameter int DEPTH    = 8,
   parameter int REC_W    = TS_W + 3 + 2 + SIZE_W + SOURCE_W + SINK_W + 2 + DATA_W,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int LVL_W   = PTR_W + 1
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                arm,
   input  logic                stop,
   input  logic                mode,
   input  logic [7:0]          op_mask,
   input  logic                d_valid,
   input  logic                d_ready,
   input  logic [2:0]          d_opcode,
   input  logic [1:0]          d_param,
   input  logic [SIZE_W-1:0]   d_size,
   input  logic [SOURCE_W-1:0] d_source,
   input  logic [SINK_W-1:0]   d_sink,
   input  logic                d_denied,
   input  logic                d_corrupt,
   input  logic [DATA_W-1:0]   d_data,
   output logic                rec_valid,
   input  logic                rec_ready,
   output logic [REC_W-1:0]    rec_data,
   output logic [1:0]          state,
   output logic [LVL_W-1:0]    level,
   output logic [15:0]         drop_count
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

   function automatic logic [TS_W-1:0] ts_sat_inc(input logic [TS_W-1:0] v);
      return (&v) ? v : v + TS_W'(1);
   endfunction

   function automatic logic [15:0] drop_sat_inc(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   state_t            state_q, state_d;
   logic [LVL_W-1:0]  level_q, level_nxt;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [TS_W-1:0]   ts_q;
   logic [15:0]       drop_q;
   logic              hit, pop, push, drop, arm_go;
   logic [REC_W-1:0]  rec_in;
   logic [REC_W-1:0]  mem [DEPTH];

   assign hit       = d_valid & d_ready & op_mask[d_opcode] & (state_q == S_CAPTURE);
   assign pop       = (level_q != '0) & rec_ready;
   // A full FIFO can still take a beat in stream mode when the head leaves this cycle.
   assign push      = hit & ((level_q != FULL) | (pop & ~mode));
   assign drop      = hit & ~push;
   assign level_nxt = level_q + LVL_W'(push) - LVL_W'(pop);
   assign rec_in    = {ts_q, d_opcode, d_param, d_size, d_source, d_sink,
                       d_denied, d_corrupt, d_data};

   always_comb begin
      state_d = state_q;
      arm_go  = 1'b0;
      case (state_q)
         S_CAPTURE: begin
            if (stop)
               state_d = S_IDLE;
            else if (mode & push & (level_nxt == FULL))
               state_d = S_DONE;
         end
         default: begin
            // stop takes priority over a simultaneous arm
            arm_go = arm & ~stop;
            if (arm_go)
               state_d = S_CAPTURE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         level_q <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ts_q    <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_nxt;
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (arm_go)
            ts_q <= '0;
         else if (state_q == S_CAPTURE)
            ts_q <= ts_sat_inc(ts_q);
         if (arm_go)
            drop_q <= '0;
         else if (drop)
            drop_q <= drop_sat_inc(drop_q);
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= rec_in;
   end

   assign rec_valid  = (level_q != '0);
   assign rec_data   = mem[rd_ptr];
   assign state      = state_q;
   assign level      = level_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_sifive_scope_tl_d_capture.sv
// Randomised and directed bench for sifive_scope_tl_d_capture against a
// queue-based reference model of the capture rules.
module tb_sifive_scope_tl_d_capture;

   localparam int DATA_W = 32, SOURCE_W = 3, SINK_W = 1, SIZE_W = 4, TS_W = 16, DEPTH = 8;
   localparam int REC_W  = TS_W + 3 + 2 + SIZE_W + SOURCE_W + SINK_W + 2 + DATA_W;
   localparam int LVL_W  = $clog2(DEPTH) + 1;

   logic                clock = 1'b0;
   logic                reset_n;
   logic                arm, stop, mode;
   logic [7:0]          op_mask;
   logic                d_valid, d_ready;
   logic [2:0]          d_opcode;
   logic [1:0]          d_param;
   logic [SIZE_W-1:0]   d_size;
   logic [SOURCE_W-1:0] d_source;
   logic [SINK_W-1:0]   d_sink;
   logic                d_denied, d_corrupt;
   logic [DATA_W-1:0]   d_data;
   logic                rec_valid, rec_ready;
   logic [REC_W-1:0]    rec_data;
   logic [1:0]          state;
   logic [LVL_W-1:0]    level;
   logic [15:0]         drop_count;

   sifive_scope_tl_d_capture #(
      .DATA_W(DATA_W), .SOURCE_W(SOURCE_W), .SINK_W(SINK_W),
      .SIZE_W(SIZE_W), .TS_W(TS_W), .DEPTH(DEPTH)
   ) dut (
      .clock(clock), .reset_n(reset_n), .arm(arm), .stop(stop), .mode(mode),
      .op_mask(op_mask), .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
      .d_param(d_param), .d_size(d_size), .d_source(d_source), .d_sink(d_sink),
      .d_denied(d_denied), .d_corrupt(d_corrupt), .d_data(d_data),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
      .state(state), .level(level), .drop_count(drop_count)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // reference model: record queue plus capture state
   logic [REC_W-1:0] mq[$];
   int               m_state = 0;
   logic [15:0]      m_ts = '0;
   logic [15:0]      m_drop = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_state = 0;
      m_ts    = '0;
      m_drop  = '0;
   endtask

   // Called at a falling edge with inputs already driven: compare, advance model, wait a cycle.
   task automatic tick();
      bit hit, pop, push, full;
      logic [REC_W-1:0] r;
      chk("rec_valid", 64'(rec_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) chk("rec_data", 64'(rec_data), 64'(mq[0]));
      chk("level", 64'(level), 64'(mq.size()));
      chk("state", 64'(state), 64'(m_state));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      hit  = d_valid && d_ready && op_mask[d_opcode] && (m_state == 1);
      pop  = (mq.size() > 0) && rec_ready;
      full = (mq.size() == DEPTH);
      push = hit && (!full || (pop && !mode));
      r = {m_ts, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data};
      if (pop) mq.delete(0);
      if (push) mq.push_back(r);
      if (m_state == 1) begin
         if (m_ts != 16'hFFFF) m_ts++;
         if (hit && !push && m_drop != 16'hFFFF) m_drop++;
         if (stop) m_state = 0;
         else if (mode && push && mq.size() == DEPTH) m_state = 2;
      end else if (arm && !stop) begin
         m_state = 1;
         m_ts    = '0;
         m_drop  = '0;
      end
      @(negedge clock);
   endtask

   task automatic idle_in();
      arm = 0; stop = 0; d_valid = 0; d_ready = 0; rec_ready = 0;
   endtask

   task automatic set_beat(input logic [2:0] op, input logic [31:0] data);
      d_valid = 1; d_ready = 1; d_opcode = op; d_data = data;
      d_param = 2'($urandom); d_size = SIZE_W'($urandom); d_source = SOURCE_W'($urandom);
      d_sink = SINK_W'($urandom); d_denied = 1'($urandom); d_corrupt = 1'($urandom);
   endtask

   task automatic pulse_arm();
      arm = 1; tick(); arm = 0;
   endtask

   task automatic pulse_stop();
      stop = 1; tick(); stop = 0;
   endtask

   task automatic drain(input int n);
      d_valid = 0; rec_ready = 1;
      repeat (n) tick();
      rec_ready = 0;
   endtask

   initial begin
      reset_n = 0; mode = 0; op_mask = '0;
      idle_in();
      set_beat(3'd0, 32'd0);
      d_valid = 0; d_ready = 0;
      repeat (2) @(negedge clock);
      reset_n = 1;
      chk("reset_state", 64'(state), 64'd0);
      chk("reset_level", 64'(level), 64'd0);
      tick();

      // opcode filter and first timestamp
      op_mask = 8'h02; mode = 0;
      pulse_arm();
      tick();
      set_beat(3'd1, 32'hA5A5_0001); tick();
      set_beat(3'd0, 32'h1234_5678); tick();
      d_valid = 0; tick();
      chk("t1_level", 64'(level), 64'd1);
      chk("t1_opcode", 64'(rec_data[46:44]), 64'd1);
      chk("t1_data", 64'(rec_data[31:0]), 64'hA5A5_0001);
      chk("t1_ts", 64'(rec_data[62:47]), 64'd1);
      drain(1);
      pulse_stop();

      // stream mode overflow then in-order drain
      op_mask = 8'hFF; mode = 0;
      pulse_arm();
      for (int i = 0; i < 11; i++) begin
         set_beat(3'($urandom), 32'(i)); tick();
      end
      d_valid = 0; tick();
      chk("t2_level", 64'(level), 64'd8);
      chk("t2_drop", 64'(drop_count), 64'd3);
      rec_ready = 1;
      for (int i = 0; i < 8; i++) begin
         chk("t2_order", 64'(rec_data[31:0]), 64'(i));
         tick();
      end
      rec_ready = 0;
      pulse_stop();

      // one-shot mode stops exactly at full
      mode = 1;
      pulse_arm();
      for (int i = 0; i < 8; i++) begin
         set_beat(3'($urandom), 32'(100 + i)); tick();
      end
      chk("t3_done", 64'(state), 64'd2);
      set_beat(3'd3, 32'hDEAD); tick();
      d_valid = 0; tick();
      chk("t3_level", 64'(level), 64'd8);
      chk("t3_drop", 64'(drop_count), 64'd0);
      drain(8);
      pulse_arm();
      chk("t3_rearm", 64'(state), 64'd1);
      set_beat(3'd2, 32'hBEEF); tick();
      d_valid = 0; tick();
      chk("t3_ts0", 64'(rec_data[62:47]), 64'd0);
      drain(1);
      pulse_stop();

      // full FIFO with simultaneous push and pop in stream mode
      mode = 0;
      pulse_arm();
      for (int i = 0; i < 8; i++) begin
         set_beat(3'($urandom), 32'(200 + i)); tick();
      end
      set_beat(3'd5, 32'(300)); rec_ready = 1; tick();
      d_valid = 0; rec_ready = 0; tick();
      chk("t4_level", 64'(level), 64'd8);
      chk("t4_drop", 64'(drop_count), 64'd0);
      drain(8);
      pulse_stop();

      // asynchronous reset with records buffered
      pulse_arm();
      for (int i = 0; i < 5; i++) begin
         set_beat(3'($urandom), $urandom); tick();
      end
      d_valid = 0;
      #2 reset_n = 0;
      #1;
      chk("t6_valid", 64'(rec_valid), 64'd0);
      chk("t6_level", 64'(level), 64'd0);
      chk("t6_state", 64'(state), 64'd0);
      chk("t6_drop", 64'(drop_count), 64'd0);
      model_reset();
      @(negedge clock);
      reset_n = 1;
      tick();

      // randomised traffic
      op_mask = 8'($urandom);
      for (int i = 0; i < 3000; i++) begin
         arm       = ($urandom_range(0, 19) == 0);
         stop      = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 199) == 0) mode = ~mode;
         if ($urandom_range(0, 299) == 0) op_mask = 8'($urandom);
         set_beat(3'($urandom), $urandom);
         d_valid   = ($urandom_range(0, 9) < 6);
         d_ready   = ($urandom_range(0, 9) < 7);
         rec_ready = ($urandom_range(0, 1) == 1);
         tick();
      end
      idle_in();
      drain(DEPTH);
      if (m_state == 1) pulse_stop();

      // timestamp saturation, then arm+stop together
      mode = 0; op_mask = 8'hFF;
      pulse_arm();
      d_valid = 0;
      repeat (65600) tick();
      set_beat(3'd4, 32'h5A5A); tick();
      d_valid = 0; tick();
      chk("t5_ts_sat", 64'(rec_data[62:47]), 64'hFFFF);
      arm = 1; stop = 1; tick();
      arm = 0; stop = 0;
      chk("t5_armstop", 64'(state), 64'd0);
      drain(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
